// File: rtl/soc_decerr_slave.sv
// AXI4 default slave: answers every write and read with DECERR and records
// the address and a saturating count of the faulting requests for debug.
module soc_decerr_slave #(
    parameter int unsigned           ID_WIDTH   = 5,
    parameter int unsigned           DATA_WIDTH = 64,
    parameter logic [DATA_WIDTH-1:0] RDATA      = 64'hBADC_AB1E_BADC_AB1E
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  aw_valid_i,
    output logic                  aw_ready_o,
    input  logic [ID_WIDTH-1:0]   aw_id_i,
    input  logic [63:0]           aw_addr_i,
    input  logic [7:0]            aw_len_i,
    input  logic                  w_valid_i,
    output logic                  w_ready_o,
    input  logic                  w_last_i,
    output logic                  b_valid_o,
    input  logic                  b_ready_i,
    output logic [ID_WIDTH-1:0]   b_id_o,
    output logic [1:0]            b_resp_o,
    input  logic                  ar_valid_i,
    output logic                  ar_ready_o,
    input  logic [ID_WIDTH-1:0]   ar_id_i,
    input  logic [63:0]           ar_addr_i,
    input  logic [7:0]            ar_len_i,
    output logic                  r_valid_o,
    input  logic                  r_ready_i,
    output logic [ID_WIDTH-1:0]   r_id_o,
    output logic [DATA_WIDTH-1:0] r_data_o,
    output logic [1:0]            r_resp_o,
    output logic                  r_last_o,
    output logic [63:0]           err_addr_o,
    output logic [15:0]           err_cnt_o
);

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    localparam logic [1:0] RESP_DECERR = 2'b11;

    w_state_e              w_state_q;
    r_state_e              r_state_q;
    logic [ID_WIDTH-1:0]   b_id_q;
    logic [ID_WIDTH-1:0]   r_id_q;
    logic [7:0]            r_cnt_q;
    logic [63:0]           err_addr_q;
    logic [63:0]           err_addr_d;
    logic [15:0]           err_cnt_q;
    logic [15:0]           err_cnt_d;
    logic [16:0]           err_sum;
    logic                  aw_hs;
    logic                  ar_hs;
    logic                  unused_aw_len;

    // Burst length of writes is taken from w_last, so the AW length is unused.
    assign unused_aw_len = ^aw_len_i;

    // Handshake signals decode state only; reset gates them off immediately.
    assign aw_ready_o = rst_ni && (w_state_q == W_IDLE);
    assign w_ready_o  = rst_ni && (w_state_q == W_DATA);
    assign b_valid_o  = rst_ni && (w_state_q == W_RESP);
    assign ar_ready_o = rst_ni && (r_state_q == R_IDLE);
    assign r_valid_o  = rst_ni && (r_state_q == R_DATA);

    assign b_id_o     = b_id_q;
    assign b_resp_o   = RESP_DECERR;
    assign r_id_o     = r_id_q;
    assign r_data_o   = RDATA;
    assign r_resp_o   = RESP_DECERR;
    assign r_last_o   = (r_state_q == R_DATA) && (r_cnt_q == 8'd0);
    assign err_addr_o = err_addr_q;
    assign err_cnt_o  = err_cnt_q;

    assign aw_hs = aw_valid_i && aw_ready_o;
    assign ar_hs = ar_valid_i && ar_ready_o;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            w_state_q <= W_IDLE;
            b_id_q    <= '0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (aw_valid_i) begin
                        b_id_q    <= aw_id_i;
                        w_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_valid_i && w_last_i) begin
                        w_state_q <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (b_ready_i) begin
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_cnt_q   <= 8'd0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (ar_valid_i) begin
                        r_id_q    <= ar_id_i;
                        r_cnt_q   <= ar_len_i;
                        r_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_ready_i) begin
                        if (r_cnt_q == 8'd0) begin
                            r_state_q <= R_IDLE;
                        end else begin
                            r_cnt_q <= r_cnt_q - 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    // Simultaneous AW and AR add two; the write address is the one recorded.
    always_comb begin
        err_sum    = {1'b0, err_cnt_q} + {16'd0, aw_hs} + {16'd0, ar_hs};
        err_cnt_d  = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        err_addr_d = err_addr_q;
        if (aw_hs) begin
            err_addr_d = aw_addr_i;
        end else if (ar_hs) begin
            err_addr_d = ar_addr_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_addr_q <= 64'd0;
            err_cnt_q  <= 16'd0;
        end else begin
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_soc_decerr_slave.sv
// Scoreboard bench for soc_decerr_slave: stimulus queues expected B/R
// responses, a negedge monitor pops and compares every handshake.
module tb_soc_decerr_slave;

    localparam int          IDW = 5;
    localparam int          DW  = 64;
    localparam logic [63:0] RD  = 64'hBADC_AB1E_BADC_AB1E;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           last;
    } r_exp_t;

    logic           clk = 1'b0;
    logic           rst_ni;
    logic           aw_valid, aw_ready;
    logic [IDW-1:0] aw_id;
    logic [63:0]    aw_addr;
    logic [7:0]     aw_len;
    logic           w_valid, w_ready, w_last;
    logic           b_valid, b_ready;
    logic [IDW-1:0] b_id;
    logic [1:0]     b_resp;
    logic           ar_valid, ar_ready;
    logic [IDW-1:0] ar_id;
    logic [63:0]    ar_addr;
    logic [7:0]     ar_len;
    logic           r_valid, r_ready;
    logic [IDW-1:0] r_id;
    logic [DW-1:0]  r_data;
    logic [1:0]     r_resp;
    logic           r_last;
    logic [63:0]    err_addr;
    logic [15:0]    err_cnt;

    logic [IDW-1:0] b_q[$];
    r_exp_t         r_q[$];
    int             checks   = 0;
    int             failures = 0;

    soc_decerr_slave #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .RDATA(RD)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id),
        .aw_addr_i(aw_addr), .aw_len_i(aw_len),
        .w_valid_i(w_valid), .w_ready_o(w_ready), .w_last_i(w_last),
        .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
        .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id),
        .ar_addr_i(ar_addr), .ar_len_i(ar_len),
        .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data),
        .r_resp_o(r_resp), .r_last_o(r_last),
        .err_addr_o(err_addr), .err_cnt_o(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_r(input logic [IDW-1:0] id, input int len);
        for (int i = 0; i <= len; i++) begin
            r_q.push_back({id, (i == len)});
        end
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while ((b_q.size() != 0 || r_q.size() != 0) && n < max_cycles) begin
            cyc();
            n++;
        end
        check("drain_pending", b_q.size() + r_q.size(), 0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_aw_ready"}, aw_ready, 0);
        check({tag, "_w_ready"},  w_ready,  0);
        check({tag, "_b_valid"},  b_valid,  0);
        check({tag, "_ar_ready"}, ar_ready, 0);
        check({tag, "_r_valid"},  r_valid,  0);
    endtask

    // Monitor: compare every handshake against the queues and check stalls hold.
    initial begin
        r_exp_t         e;
        logic [IDW-1:0] eb;
        logic           r_hold, b_hold, hold_last;
        logic [IDW-1:0] hold_rid, hold_bid;
        logic [DW-1:0]  hold_data;
        r_hold = 1'b0;
        b_hold = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_ni !== 1'b1) begin
                r_hold = 1'b0;
                b_hold = 1'b0;
            end else begin
                if (r_hold) begin
                    check("r_stall_valid", r_valid, 1);
                    check("r_stall_id",    r_id,    hold_rid);
                    check("r_stall_last",  r_last,  hold_last);
                    check("r_stall_data",  r_data,  hold_data);
                end
                if (b_hold) begin
                    check("b_stall_valid", b_valid, 1);
                    check("b_stall_id",    b_id,    hold_bid);
                end
                if (r_valid && r_ready) begin
                    if (r_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL r_unexpected actual=beat id=0x%0h required=no beat", r_id);
                    end else begin
                        e = r_q.pop_front();
                        check("r_id",   r_id,   e.id);
                        check("r_last", r_last, e.last);
                        check("r_data", r_data, RD);
                        check("r_resp", r_resp, 2'b11);
                    end
                end
                if (b_valid && b_ready) begin
                    if (b_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL b_unexpected actual=resp id=0x%0h required=no resp", b_id);
                    end else begin
                        eb = b_q.pop_front();
                        check("b_id",   b_id,   eb);
                        check("b_resp", b_resp, 2'b11);
                    end
                end
                r_hold    = r_valid && !r_ready;
                b_hold    = b_valid && !b_ready;
                hold_rid  = r_id;
                hold_last = r_last;
                hold_data = r_data;
                hold_bid  = b_id;
            end
        end
    end

    initial begin
        #1_500_000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int issued;
        int need;
        int guard;
        int n;

        rst_ni = 1'b0;
        aw_valid = 0; aw_id = '0; aw_addr = '0; aw_len = '0;
        w_valid = 0; w_last = 0; b_ready = 1;
        ar_valid = 0; ar_id = '0; ar_addr = '0; ar_len = '0;
        r_ready = 1;

        // Reset state
        #1;
        check_quiet("rst0");
        repeat (3) cyc();
        check_quiet("rst1");
        check("rst_err_cnt",  err_cnt,  0);
        check("rst_err_addr", err_addr, 0);
        rst_ni = 1'b1;
        #1;
        check("post_rst_aw_ready", aw_ready, 1);
        check("post_rst_ar_ready", ar_ready, 1);
        cyc();

        // Single write, 4 beats
        aw_valid = 1; aw_id = 5'h13; aw_addr = 64'h5000_0000; aw_len = 8'd3;
        b_q.push_back(5'h13);
        check("wr_w_ready_aw_cycle", w_ready, 0);
        cyc();
        aw_valid = 0;
        check("wr_aw_ready_busy", aw_ready, 0);
        check("wr_w_ready_after_aw", w_ready, 1);
        check("wr_err_cnt",  err_cnt,  1);
        check("wr_err_addr", err_addr, 64'h5000_0000);
        for (int i = 0; i < 4; i++) begin
            w_valid = 1;
            w_last  = (i == 3);
            cyc();
        end
        w_valid = 0; w_last = 0;
        check("wr_b_valid_latency", b_valid, 1);
        cyc();
        check("wr_b_done", b_valid, 0);
        check("wr_aw_ready_idle", aw_ready, 1);
        drain(5);

        // Single-beat read
        ar_valid = 1; ar_id = 5'd2; ar_addr = 64'h6000_0000; ar_len = 8'd0;
        push_r(5'd2, 0);
        cyc();
        ar_valid = 0;
        check("rd1_r_valid", r_valid, 1);
        check("rd1_err_cnt",  err_cnt,  2);
        check("rd1_err_addr", err_addr, 64'h6000_0000);
        cyc();
        check("rd1_one_beat", r_valid, 0);
        drain(5);

        // 256-beat read with r_ready toggling
        ar_valid = 1; ar_id = 5'd7; ar_addr = 64'h6100_0000; ar_len = 8'd255;
        push_r(5'd7, 255);
        cyc();
        ar_valid = 0;
        n = 0;
        while (r_q.size() != 0 && n < 1000) begin
            r_ready = ~r_ready;
            cyc();
            n++;
        end
        r_ready = 1;
        check("long_remaining", r_q.size(), 0);
        check("long_done", r_valid, 0);
        check("long_err_cnt", err_cnt, 3);

        // W beat presented before its AW
        w_valid = 1; w_last = 1;
        for (int i = 0; i < 3; i++) begin
            check("early_w_ready", w_ready, 0);
            cyc();
        end
        aw_valid = 1; aw_id = 5'd4; aw_addr = 64'h7000_0000;
        b_q.push_back(5'd4);
        check("early_w_ready_aw_cycle", w_ready, 0);
        cyc();
        aw_valid = 0;
        check("early_w_ready_after_aw", w_ready, 1);
        cyc();
        w_valid = 0; w_last = 0;
        check("early_b_valid", b_valid, 1);
        drain(10);
        check("early_err_cnt", err_cnt, 4);

        // Preload the fault counter to 0xFFFE using both paths back to back
        need = 32'hFFFE - 4;
        issued = 0;
        guard = 0;
        w_valid = 1; w_last = 1;
        while (issued < need && guard < 100000) begin
            aw_valid = 0;
            ar_valid = 0;
            if (aw_ready && issued < need) begin
                aw_valid = 1;
                aw_id    = IDW'(issued);
                aw_addr  = 64'h1_0000 + 64'(issued);
                b_q.push_back(IDW'(issued));
                issued++;
            end
            if (ar_ready && issued < need) begin
                ar_valid = 1;
                ar_id    = IDW'(issued);
                ar_addr  = 64'h2_0000 + 64'(issued);
                ar_len   = 8'd0;
                push_r(IDW'(issued), 0);
                issued++;
            end
            cyc();
            guard++;
        end
        aw_valid = 0; ar_valid = 0;
        check("preload_issued", issued, need);
        drain(20);
        w_valid = 0; w_last = 0;
        check("preload_err_cnt", err_cnt, 16'hFFFE);

        // Simultaneous AW and AR: saturate at 0xFFFF, write address wins
        aw_valid = 1; aw_id = 5'd1; aw_addr = 64'hA;
        ar_valid = 1; ar_id = 5'd3; ar_addr = 64'hB; ar_len = 8'd2;
        b_q.push_back(5'd1);
        push_r(5'd3, 2);
        cyc();
        aw_valid = 0; ar_valid = 0;
        check("sim_err_cnt_sat", err_cnt, 16'hFFFF);
        check("sim_err_addr",    err_addr, 64'hA);
        w_valid = 1; w_last = 1;
        drain(20);
        w_valid = 0; w_last = 0;

        // Reset during beat 2 of an 8-beat read
        ar_valid = 1; ar_id = 5'd6; ar_addr = 64'h8000; ar_len = 8'd7;
        push_r(5'd6, 7);
        cyc();
        ar_valid = 0;
        cyc();
        cyc();
        rst_ni = 1'b0;
        r_q.delete();
        #1;
        check_quiet("mid_rst0");
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_quiet("mid_rst1");
        end
        check("mid_rst_err_cnt",  err_cnt,  0);
        check("mid_rst_err_addr", err_addr, 0);
        rst_ni = 1'b1;
        ar_valid = 1; ar_id = 5'd9; ar_addr = 64'h9000; ar_len = 8'd0;
        push_r(5'd9, 0);
        #1;
        check("mid_rst_ar_ready", ar_ready, 1);
        cyc();
        ar_valid = 0;
        check("mid_rst_new_err_cnt",  err_cnt,  1);
        check("mid_rst_new_err_addr", err_addr, 64'h9000);
        check("mid_rst_new_r_id",     r_id,     5'd9);
        drain(10);
        cyc();
        check("mid_rst_idle", r_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
